// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter.
//   state_e  : FSM encodings (ST_CLEAR = zero-fill sweep, ST_ARB = arbitration)
//   depth_of : number of register entries for a given address width
package regfile_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_ARB   = 2'd1
  } state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Bundle of the two requester ports, the init command and the shared
// result/status signals of the register-file arbiter.
//   master : requester side (drives init, reqN, weN, addrN, wdataN)
//   slave  : arbiter side (drives gntN, rvalidN, rdata, activo, done)
interface regfile_port_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              init;
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              activo;
  logic              done;

  modport master (
    output init, req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, activo, done
  );

  modport slave (
    input  init, req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, activo, done
  );
endinterface

// File: rtl/regfile_mem.sv
// Register-file storage: DEPTH x DATA_W array, one synchronous write port
// and one registered read port. Contents are not reset; only the read
// register is cleared so rdata starts at zero.
//   clk, srst          : clock / synchronous active-high reset of read register
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i       : read enable / address
//   rdata_o            : registered read data (holds when re_i is low)
module regfile_mem
  import regfile_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Register file shared by two requesters through a single access port.
// After reset or an init command a sweep writes zero to every entry
// (activo high, no grants, done pulses on the last write). Outside the
// sweep one transaction per cycle is granted with round-robin priority.
//   clk  : clock
//   Mrst : synchronous active-high reset; forces gnt/activo/done low while high
//   bus  : slave side of regfile_port_arbiter_if (requests, grants, read data)
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic clk,
  input  logic Mrst,
  regfile_port_arbiter_if.slave bus
);
  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              prio_q;      // port that wins when both request
  logic              rvalid0_q;
  logic              rvalid1_q;

  logic              gnt0_d;
  logic              gnt1_d;
  logic              activo_d;
  logic              done_d;
  logic              clearing;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  // Grants are same-cycle combinational; everything is suppressed in reset.
  always_comb begin
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    activo_d = 1'b0;
    done_d   = 1'b0;
    if (!Mrst) begin
      case (state_q)
        ST_CLEAR: begin
          activo_d = 1'b1;
          done_d   = (cnt_q == CNT_LAST);
        end
        ST_ARB: begin
          // init takes precedence over any pending request
          if (!bus.init) begin
            gnt0_d = bus.req0 & (~bus.req1 | ~prio_q);
            gnt1_d = bus.req1 & (~bus.req0 |  prio_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign clearing = activo_d;

  // Single storage port: the sweep owns it while clearing, otherwise the
  // granted requester does. At most one grant exists, so the mux is safe.
  assign mem_we    = clearing | (gnt0_d & bus.we0) | (gnt1_d & bus.we1);
  assign mem_waddr = clearing ? cnt_q : (gnt1_d ? bus.addr1 : bus.addr0);
  assign mem_wdata = clearing ? '0    : (gnt1_d ? bus.wdata1 : bus.wdata0);
  assign mem_re    = (gnt0_d & ~bus.we0) | (gnt1_d & ~bus.we1);
  assign mem_raddr = gnt1_d ? bus.addr1 : bus.addr0;

  regfile_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .srst    (Mrst),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (Mrst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      prio_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= gnt0_d & ~bus.we0;
      rvalid1_q <= gnt1_d & ~bus.we1;
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          // Leave on the last entry explicitly rather than relying on wrap.
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (bus.init) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end else if (gnt0_d) begin
            prio_q <= 1'b1;
          end else if (gnt1_d) begin
            prio_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt0    = gnt0_d;
  assign bus.gnt1    = gnt1_d;
  assign bus.activo  = activo_d;
  assign bus.done    = done_d;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = mem_rdata;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed testbench for regfile_port_arbiter: reset sweep timing,
// write/read through both ports, round-robin, init precedence,
// reset during a sweep and priority pointer update.
module tb_regfile_port_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic clk;
  logic Mrst;
  int   checks;
  int   failures;

  regfile_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .Mrst (Mrst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.init = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  // Reset for 2 cycles with req0 held; activo cycles 1..8, done in 8, gnt0 in 9.
  task automatic test_reset();
    logic exp_act, exp_done, exp_gnt;
    idle_inputs();
    Mrst = 1'b1;
    bus.req0 = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.activo !== 1'b0) begin failures++; $display("FAIL reset_activo got=%b exp=0", bus.activo); end
    checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%b exp=0", bus.gnt0); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
    checks++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", bus.rvalid0, bus.rvalid1); end
    next_cycle();
    Mrst = 1'b0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      exp_act  = (cyc <= 8);
      exp_done = (cyc == 8);
      exp_gnt  = (cyc == 9);
      @(negedge clk);
      checks++; if (bus.activo !== exp_act) begin failures++; $display("FAIL sweep_activo cyc=%0d got=%b exp=%b", cyc, bus.activo, exp_act); end
      checks++; if (bus.done !== exp_done) begin failures++; $display("FAIL sweep_done cyc=%0d got=%b exp=%b", cyc, bus.done, exp_done); end
      checks++; if (bus.gnt0 !== exp_gnt) begin failures++; $display("FAIL sweep_gnt0 cyc=%0d got=%b exp=%b", cyc, bus.gnt0, exp_gnt); end
      next_cycle();
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    $display("txn: port0 read addr 0 after reset sweep");
    checks++; if (bus.rvalid0 !== 1'b1) begin failures++; $display("FAIL reset_read_rvalid0 got=%b exp=1", bus.rvalid0); end
    checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL reset_read_rdata got=%h exp=00", bus.rdata); end
    next_cycle();
  endtask

  task automatic test_write_read();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd5; bus.wdata0 = 8'hA5;
    @(negedge clk);
    checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b exp=10", bus.gnt0, bus.gnt1); end
    $display("txn: port0 write addr 5 data a5");
    next_cycle();
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd5;
    @(negedge clk);
    checks++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin failures++; $display("FAIL rd_gnt got=%b%b exp=01", bus.gnt0, bus.gnt1); end
    $display("txn: port1 read addr 5");
    next_cycle();
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++; if (bus.rvalid1 !== 1'b1) begin failures++; $display("FAIL rd_rvalid1 got=%b exp=1", bus.rvalid1); end
    checks++; if (bus.rdata !== 8'hA5) begin failures++; $display("FAIL rd_rdata got=%h exp=a5", bus.rdata); end
    checks++; if (bus.rvalid0 !== 1'b0) begin failures++; $display("FAIL rd_rvalid0 got=%b exp=0", bus.rvalid0); end
    next_cycle();
  endtask

  // prio is 0 here (last grant went to port 1).
  task automatic test_round_robin();
    logic exp0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd2;
    for (int k = 0; k < 4; k++) begin
      exp0 = (k % 2 == 0);
      @(negedge clk);
      checks++; if (bus.gnt0 !== exp0) begin failures++; $display("FAIL rr_gnt0 k=%0d got=%b exp=%b", k, bus.gnt0, exp0); end
      checks++; if (bus.gnt1 !== ~exp0) begin failures++; $display("FAIL rr_gnt1 k=%0d got=%b exp=%b", k, bus.gnt1, ~exp0); end
      checks++; if ((bus.gnt0 & bus.gnt1) !== 1'b0) begin failures++; $display("FAIL rr_both k=%0d got=%b%b exp=one", k, bus.gnt0, bus.gnt1); end
      if (k > 0) begin
        checks++; if (bus.rvalid0 !== ~exp0) begin failures++; $display("FAIL rr_rvalid0 k=%0d got=%b exp=%b", k, bus.rvalid0, ~exp0); end
      end
      $display("txn: round-robin grant k=%0d gnt0=%b gnt1=%b", k, bus.gnt0, bus.gnt1);
      next_cycle();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    checks++; if (bus.rvalid1 !== 1'b1 || bus.rdata !== 8'h00) begin failures++; $display("FAIL rr_last_read got=%b/%h exp=1/00", bus.rvalid1, bus.rdata); end
    next_cycle();
  endtask

  task automatic test_init_priority();
    logic exp_act, exp_gnt;
    int   act_cnt;
    act_cnt = 0;
    bus.init = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd5;
    @(negedge clk);
    checks++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin failures++; $display("FAIL init_nogrant got=%b%b exp=00", bus.gnt0, bus.gnt1); end
    $display("txn: init with req0 pending");
    next_cycle();
    bus.init = 1'b0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      exp_act = (cyc <= 8);
      exp_gnt = (cyc == 9);
      @(negedge clk);
      if (bus.activo === 1'b1) act_cnt++;
      checks++; if (bus.activo !== exp_act) begin failures++; $display("FAIL init_activo cyc=%0d got=%b exp=%b", cyc, bus.activo, exp_act); end
      checks++; if (bus.gnt0 !== exp_gnt) begin failures++; $display("FAIL init_gnt0 cyc=%0d got=%b exp=%b", cyc, bus.gnt0, exp_gnt); end
      next_cycle();
    end
    checks++; if (act_cnt !== 8) begin failures++; $display("FAIL init_activo_len got=%0d exp=8", act_cnt); end
    bus.req0 = 1'b0;
    @(negedge clk);
    $display("txn: port0 read addr 5 after init sweep");
    checks++; if (bus.rvalid0 !== 1'b1) begin failures++; $display("FAIL init_read_rvalid0 got=%b exp=1", bus.rvalid0); end
    checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL init_read_rdata got=%h exp=00", bus.rdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid_sweep();
    logic exp_act, exp_done;
    int   done_cnt;
    done_cnt = 0;
    bus.init = 1'b1;
    @(negedge clk);
    checks++; if (bus.activo !== 1'b0) begin failures++; $display("FAIL mid_pre_activo got=%b exp=0", bus.activo); end
    next_cycle();
    bus.init = 1'b0;
    for (int cyc = 1; cyc <= 2; cyc++) begin
      @(negedge clk);
      checks++; if (bus.activo !== 1'b1) begin failures++; $display("FAIL mid_activo cyc=%0d got=%b exp=1", cyc, bus.activo); end
      next_cycle();
    end
    Mrst = 1'b1;
    @(negedge clk);
    $display("txn: reset at sweep cycle 3");
    checks++; if (bus.activo !== 1'b0) begin failures++; $display("FAIL mid_rst_activo got=%b exp=0", bus.activo); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", bus.done); end
    next_cycle();
    Mrst = 1'b0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      exp_act  = (cyc <= 8);
      exp_done = (cyc == 8);
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
      checks++; if (bus.activo !== exp_act) begin failures++; $display("FAIL restart_activo cyc=%0d got=%b exp=%b", cyc, bus.activo, exp_act); end
      checks++; if (bus.done !== exp_done) begin failures++; $display("FAIL restart_done cyc=%0d got=%b exp=%b", cyc, bus.done, exp_done); end
      next_cycle();
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
  endtask

  // prio is 0 after the reset above.
  task automatic test_prio_update();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin failures++; $display("FAIL prio_solo k=%0d got=%b%b exp=01", k, bus.gnt0, bus.gnt1); end
      $display("txn: port1 solo read k=%0d", k);
      next_cycle();
    end
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd4;
    @(negedge clk);
    checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin failures++; $display("FAIL prio_both_first got=%b%b exp=10", bus.gnt0, bus.gnt1); end
    $display("txn: both request, first grant");
    next_cycle();
    @(negedge clk);
    checks++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin failures++; $display("FAIL prio_both_second got=%b%b exp=01", bus.gnt0, bus.gnt1); end
    $display("txn: both request, second grant");
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Mrst     = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_init_priority();
    test_reset_mid_sweep();
    test_prio_update();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
